cellram_arbiter: RTL and testbench

- Sequences the board's asynchronous 512K x 8 cellular RAM (19-bit address, 8-bit data) and shares it between two on-chip requesters.
- Owns the chip strobes and the split tristate data bus that feeds the per-bit IOBUF array.
- Runs a round-robin grant, a read/write timing FSM and a bus-turnaround recovery cycle.
- Sits beside the AXI block design as a fabric-side RAM path clocked from clk_100mhz.

---
 rtl/cellram_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cellram_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellram_arbiter.sv
// Two-port round-robin arbiter and read/write timing sequencer for the 512K x 8 cellular RAM.
// Define CELLRAM_FIXED_PRIO_EN to give port 0 strict priority instead of round-robin.
module cellram_arbiter #(
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic              clk_100mhz,
    input  logic              reset_n,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_o,
    output logic [DATA_W-1:0] mem_t,
    input  logic [DATA_W-1:0] mem_i,
    output logic              ram_ce_n,
    output logic              ram_we_n,
    output logic              ram_oe_n,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;

    if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
        $error("cellram_arbiter: RD_WAIT must be in 1..15");
    end
    if (WR_WAIT < 1 || WR_WAIT > 15) begin : g_bad_wr_wait
        $error("cellram_arbiter: WR_WAIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD_ACT = 2'd1,
        S_WR_ACT = 2'd2,
        S_RECOV  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_port;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_o;
    logic [DATA_W-1:0]  r_mem_t;
    logic               r_ce_n;
    logic               r_we_n;
    logic               r_oe_n;
    logic               r_busy;
    logic [DATA_W-1:0]  r_p0_rdata;
    logic [DATA_W-1:0]  r_p1_rdata;
    logic               r_p0_rvalid;
    logic               r_p1_rvalid;

    logic               w_gnt;
    logic               w_xfer;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;

    // Grant selection: 0 = port 0, 1 = port 1
`ifdef CELLRAM_FIXED_PRIO_EN
    assign w_gnt = ~p0_valid;
`else
    logic r_last_grant;
    assign w_gnt = (p0_valid & p1_valid) ? ~r_last_grant : ~p0_valid;
`endif

    assign w_xfer   = (r_state == S_IDLE) & (p0_valid | p1_valid);
    assign p0_ready = w_xfer & ~w_gnt;
    assign p1_ready = w_xfer & w_gnt;
    assign w_we     = w_gnt ? p1_we    : p0_we;
    assign w_addr   = w_gnt ? p1_addr  : p0_addr;
    assign w_wdata  = w_gnt ? p1_wdata : p0_wdata;

    // Sequencer: strobes, bus direction and read capture all come from these flops
    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_port      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_o     <= '0;
            r_mem_t     <= '1;
            r_ce_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
`ifndef CELLRAM_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_port     <= w_gnt;
                        r_mem_addr <= w_addr;
                        r_ce_n     <= 1'b0;
                        r_busy     <= 1'b1;
`ifndef CELLRAM_FIXED_PRIO_EN
                        r_last_grant <= w_gnt;
`endif
                        if (w_we) begin
                            r_state <= S_WR_ACT;
                            r_we_n  <= 1'b0;
                            r_mem_t <= '0;
                            r_mem_o <= w_wdata;
                            r_cnt   <= CNT_W'(WR_WAIT - 1);
                        end else begin
                            r_state <= S_RD_ACT;
                            r_oe_n  <= 1'b0;
                            r_cnt   <= CNT_W'(RD_WAIT - 1);
                        end
                    end
                end
                S_RD_ACT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RECOV;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        if (r_port) begin
                            r_p1_rdata  <= mem_i;
                            r_p1_rvalid <= 1'b1;
                        end else begin
                            r_p0_rdata  <= mem_i;
                            r_p0_rvalid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WR_ACT: begin
                    // Bus stays driven through RECOV for data/address hold
                    if (r_cnt == '0) begin
                        r_state <= S_RECOV;
                        r_ce_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RECOV: begin
                    r_state <= S_IDLE;
                    r_mem_t <= '1;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_o     = r_mem_o;
    assign mem_t     = r_mem_t;
    assign ram_ce_n  = r_ce_n;
    assign ram_we_n  = r_we_n;
    assign ram_oe_n  = r_oe_n;
    assign busy      = r_busy;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;
    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;

endmodule

// File: tb/tb_cellram_arbiter.sv
// Scoreboard bench for cellram_arbiter: randomized two-port traffic, a behavioural RAM device
// on the pins, and a transaction-level reference model predicting grants, strobes and read data.
module tb_cellram_arbiter;

    localparam int unsigned AW  = 19;
    localparam int unsigned DW  = 8;
    localparam int unsigned RDW = 2;
    localparam int unsigned WRW = 2;

    logic          clk_100mhz = 1'b0;
    logic          reset_n    = 1'b0;
    logic          p0_valid, p0_ready, p0_we, p0_rvalid;
    logic          p1_valid, p1_ready, p1_we, p1_rvalid;
    logic [AW-1:0] p0_addr, p1_addr, mem_addr;
    logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
    logic [DW-1:0] mem_o, mem_t;
    logic [DW-1:0] mem_i = '0;
    logic          ram_ce_n, ram_we_n, ram_oe_n, busy;

    cellram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
        .clk_100mhz(clk_100mhz), .reset_n(reset_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .mem_addr(mem_addr), .mem_o(mem_o), .mem_t(mem_t), .mem_i(mem_i),
        .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n), .busy(busy)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            pat;
        bit            must;
    } req_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } rsp_t;

    req_t rq0[$], rq1[$];
    rsp_t eq0[$], eq1[$];
    int   n_chk = 0, n_err = 0, cyc = 0, acc_cnt = 0;

    logic [DW-1:0] dev[logic [AW-1:0]];
    logic [DW-1:0] shadow[logic [AW-1:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Power-up contents of the RAM device (shared knowledge of bench device and model)
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return DW'(a ^ (a >> 8) ^ (a >> 16) ^ 19'h3C);
    endfunction

    function automatic logic [DW-1:0] dev_rd(input logic [AW-1:0] a);
        return dev.exists(a) ? dev[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    always @(posedge clk_100mhz) cyc <= cyc + 1;

    // Reference model state
    bit            pin_on = 0, m_act = 0, m_we = 0, m_fresh = 1, m_lg = 1;
    int            m_acc = 0, m_earliest = 0, m_d, m_w;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, exp_rd0 = '0, exp_rd1 = '0;
    bit            e_ce, e_we, e_oe, e_busy, e_r0, e_r1, g;
    logic [DW-1:0] e_t;
    rsp_t          rr;

    // Device model, pin/scoreboard monitor and arbitration model, evaluated mid-cycle
    always @(negedge clk_100mhz) begin
        if (!ram_ce_n && !ram_we_n && mem_t == 8'h00) dev[mem_addr] = mem_o;
        mem_i = (!ram_ce_n && !ram_oe_n) ? dev_rd(mem_addr) : DW'($urandom);

        if (pin_on) begin
            e_ce = 1; e_we = 1; e_oe = 1; e_busy = 0; e_t = 8'hFF;
            m_d = cyc - m_acc;
            m_w = m_we ? int'(WRW) : int'(RDW);
            if (m_act && m_d <= m_w) begin
                e_busy = 1;
                if (m_d < m_w) begin
                    e_ce = 0;
                    if (m_we) e_we = 0; else e_oe = 0;
                end
                if (m_we) e_t = 8'h00;
            end
            chk("strobes{ce,we,oe,busy,t}", 32'({ram_ce_n, ram_we_n, ram_oe_n, busy, mem_t}),
                32'({e_ce, e_we, e_oe, e_busy, e_t}));
            chk("no_contention", 32'(mem_t != 8'hFF && !ram_oe_n), 32'(0));
            if (m_fresh) chk("reset_addr_o", 32'({mem_addr, mem_o}), 32'(0));
            else if (e_busy) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (m_act && m_we && m_d <= m_w) chk("mem_o", 32'(mem_o), 32'(m_wdata));

            if (p0_rvalid) begin
                if (eq0.size() == 0) chk("p0_rvalid_unexpected", 32'(1), 32'(0));
                else begin
                    rr = eq0.pop_front();
                    chk("p0_rvalid_cycle", 32'(cyc), 32'(rr.cyc));
                    chk("p0_rdata", 32'(p0_rdata), 32'(rr.data));
                    exp_rd0 = rr.data;
                end
            end else begin
                chk("p0_rdata_hold", 32'(p0_rdata), 32'(exp_rd0));
                if (eq0.size() > 0 && eq0[0].cyc < cyc) begin
                    chk("p0_rvalid_missing", 32'(0), 32'(1));
                    void'(eq0.pop_front());
                end
            end
            if (p1_rvalid) begin
                if (eq1.size() == 0) chk("p1_rvalid_unexpected", 32'(1), 32'(0));
                else begin
                    rr = eq1.pop_front();
                    chk("p1_rvalid_cycle", 32'(cyc), 32'(rr.cyc));
                    chk("p1_rdata", 32'(p1_rdata), 32'(rr.data));
                    exp_rd1 = rr.data;
                end
            end else begin
                chk("p1_rdata_hold", 32'(p1_rdata), 32'(exp_rd1));
                if (eq1.size() > 0 && eq1[0].cyc < cyc) begin
                    chk("p1_rvalid_missing", 32'(0), 32'(1));
                    void'(eq1.pop_front());
                end
            end
        end

        // Predict what happens at the coming rising edge
        if (!reset_n) begin
            m_act = 0; m_lg = 1; m_fresh = 1; m_earliest = cyc + 2;
            eq0.delete(); eq1.delete();
            exp_rd0 = '0; exp_rd1 = '0;
            pin_on = 1;
        end else begin
            e_r0 = 0; e_r1 = 0;
            if (cyc + 1 >= m_earliest && (p0_valid || p1_valid)) begin
`ifdef CELLRAM_FIXED_PRIO_EN
                g = !p0_valid;
`else
                g = (p0_valid && p1_valid) ? !m_lg : !p0_valid;
`endif
                e_r0 = !g; e_r1 = g;
                m_lg = g; m_act = 1; m_fresh = 0; m_acc = cyc + 1; acc_cnt++;
                m_we    = g ? p1_we    : p0_we;
                m_addr  = g ? p1_addr  : p0_addr;
                m_wdata = g ? p1_wdata : p0_wdata;
                m_earliest = m_acc + (m_we ? int'(WRW) : int'(RDW)) + 2;
                if (m_we) shadow[m_addr] = m_wdata;
                else begin
                    rr.cyc  = m_acc + int'(RDW);
                    rr.data = sh_rd(m_addr);
                    if (g) eq1.push_back(rr); else eq0.push_back(rr);
                end
            end
            if (pin_on) chk("ready{p0,p1}", 32'({p0_ready, p1_ready}), 32'({e_r0, e_r1}));
        end
    end

    // Requester driver: both ports in one process, requests held until accepted or abandoned
    req_t cur[2];
    bit   cact[2], fin[2], acc[2];
    int   waited[2];

    initial begin
        p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        cact[0] = 0; cact[1] = 0;
        forever begin
            @(negedge clk_100mhz);
            for (int p = 0; p < 2; p++) begin
                fin[p] = 0; acc[p] = 0;
                if (cact[p]) begin
                    if (reset_n && (p == 0 ? p0_ready : p1_ready)) begin
                        fin[p] = 1; acc[p] = 1;
                    end else begin
                        waited[p]++;
                        if (waited[p] >= cur[p].pat) fin[p] = 1;
                    end
                end
            end
            @(posedge clk_100mhz);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (fin[p]) begin
                    if (cur[p].must) chk($sformatf("accept_p%0d", p), 32'(acc[p]), 32'(1));
                    cact[p] = 0;
                end
                if (!cact[p]) begin
                    if (p == 0 && rq0.size() > 0) begin cur[0] = rq0.pop_front(); cact[0] = 1; waited[0] = 0; end
                    if (p == 1 && rq1.size() > 0) begin cur[1] = rq1.pop_front(); cact[1] = 1; waited[1] = 0; end
                end
            end
            p0_valid = cact[0];
            p0_we    = cact[0] ? cur[0].we   : 1'($urandom);
            p0_addr  = cact[0] ? cur[0].addr : AW'($urandom);
            p0_wdata = cact[0] ? cur[0].data : DW'($urandom);
            p1_valid = cact[1];
            p1_we    = cact[1] ? cur[1].we   : 1'($urandom);
            p1_addr  = cact[1] ? cur[1].addr : AW'($urandom);
            p1_wdata = cact[1] ? cur[1].data : DW'($urandom);
        end
    end

    task automatic push(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit must, input int pat);
        req_t r;
        r.we = we; r.addr = a; r.data = d; r.must = must; r.pat = pat;
        if (p == 0) rq0.push_back(r); else rq1.push_back(r);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || cact[0] || cact[1]) && t < 5000) begin
            @(posedge clk_100mhz);
            t++;
        end
        chk("drain_in_time", 32'(t < 5000), 32'(1));
        repeat (8) @(posedge clk_100mhz);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return AW'($urandom);
            default: return 19'h12340 + AW'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        int n0, t, p;
        reset_n = 0;
        repeat (3) @(posedge clk_100mhz);
        #1 reset_n = 1;

        @(negedge clk_100mhz);
        push(0, 1'b1, 19'h12345, 8'hA5, 1, 300);
        wait_idle();
        push(0, 1'b0, 19'h12345, 8'h00, 1, 300);
        wait_idle();

        // Both ports continuously valid
        @(negedge clk_100mhz);
        push(0, 1'b0, 19'h12345, 8'h00, 1, 300);
        push(1, 1'b0, 19'h00042, 8'h00, 1, 300);
        push(0, 1'b0, 19'h7FFFF, 8'h00, 1, 300);
        push(1, 1'b0, 19'h12345, 8'h00, 1, 300);
        wait_idle();

        // Write then read back-to-back on port 1
        @(negedge clk_100mhz);
        push(1, 1'b1, 19'h0ABCD, 8'h3C, 1, 300);
        push(1, 1'b0, 19'h0ABCD, 8'h00, 1, 300);
        wait_idle();

        // Reset during the second read-active cycle
        n0 = acc_cnt;
        @(negedge clk_100mhz);
        push(0, 1'b0, 19'h12345, 8'h00, 1, 300);
        t = 0;
        while (acc_cnt == n0 && t < 2000) begin #1; t++; end
        chk("rst_test_accept", 32'(acc_cnt - n0), 32'(1));
        @(posedge clk_100mhz);
        @(posedge clk_100mhz);
        #1 reset_n = 0;
        @(posedge clk_100mhz);
        #1 reset_n = 1;
        @(negedge clk_100mhz);
        push(1, 1'b0, 19'h0ABCD, 8'h00, 1, 300);
        push(0, 1'b0, 19'h12345, 8'h00, 1, 300);
        wait_idle();

        // Randomized traffic with occasional abandoned requests
        for (int i = 0; i < 250; i++) begin
            @(negedge clk_100mhz);
            while (rq0.size() + rq1.size() > 3) @(negedge clk_100mhz);
            if ($urandom_range(0, 3) != 0) begin
                p = int'($urandom_range(0, 1));
                if ($urandom_range(0, 4) != 0)
                    push(p, 1'($urandom), pick_addr(), DW'($urandom), 1, 300);
                else
                    push(p, 1'($urandom), pick_addr(), DW'($urandom), 0, int'($urandom_range(1, 6)));
            end
        end
        wait_idle();
        chk("responses_outstanding", 32'(eq0.size() + eq1.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
